// File: rtl/lfsr_prng.sv
// lfsr_prng: parametrised Fibonacci LFSR pseudo-random source.
// Provides seed load, gated stepping, an edge-detected sample strobe that
// captures the current and previous states, a lock-up flag and a pulse that
// marks the return to the start state.
// Optional feature macro: LFSR_ZERO_GUARD_EN (all-zero state is replaced by SEED).
module lfsr_prng #(
  parameter int              WIDTH = 14,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(14'h2221),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(14'h0001)
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             step_en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             sample,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_2_dis,
  output logic             sample_vld,
  output logic             lockup,
  output logic             wrap
);

  // Shift left, parity of the tapped bits enters at bit 0.
  function automatic logic [WIDTH-1:0] f_lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_prev;
  logic             r_sample_q;
  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_data_2_dis;
  logic             r_sample_vld;
  logic             r_wrap;

  logic [WIDTH-1:0] w_sreg_nxt;
  logic [WIDTH-1:0] w_start_nxt;
  logic             w_upd;
  logic             w_wrap_nxt;
  logic             w_edge;

  // Next LFSR state: load has priority over step; hold otherwise.
  always_comb begin
    w_sreg_nxt  = r_sreg;
    w_start_nxt = r_start;
    w_upd       = 1'b0;
    w_wrap_nxt  = 1'b0;
    if (load) begin
      w_upd = 1'b1;
`ifdef LFSR_ZERO_GUARD_EN
      w_sreg_nxt = (seed_in == '0) ? SEED : seed_in;
`else
      w_sreg_nxt = seed_in;
`endif
      w_start_nxt = w_sreg_nxt;
    end else if (step_en) begin
      w_upd = 1'b1;
`ifdef LFSR_ZERO_GUARD_EN
      w_sreg_nxt = (r_sreg == '0) ? SEED : f_lfsr_next(r_sreg);
`else
      w_sreg_nxt = f_lfsr_next(r_sreg);
`endif
      w_wrap_nxt = (w_sreg_nxt == r_start);
    end
  end

  assign w_edge = sample & ~r_sample_q;

  // LFSR state, start value, previous state and wrap pulse.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_sreg  <= SEED;
      r_start <= SEED;
      r_prev  <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_sreg  <= w_sreg_nxt;
      r_start <= w_start_nxt;
      if (w_upd) r_prev <= r_sreg;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Sample edge detect; captures pre-update state and previous state.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_sample_q   <= 1'b0;
      r_data_out   <= '0;
      r_data_2_dis <= '0;
      r_sample_vld <= 1'b0;
    end else begin
      r_sample_q   <= sample;
      r_sample_vld <= w_edge;
      if (w_edge) begin
        r_data_out   <= r_sreg;
        r_data_2_dis <= r_prev;
      end
    end
  end

`ifdef LFSR_ZERO_GUARD_EN
  // The guard makes the all-zero state unreachable.
  assign lockup = 1'b0;
`else
  logic r_lockup;

  // Lock-up flag tracks the all-zero state alongside the state register.
  always_ff @(posedge sysclk) begin
    if (rst) r_lockup <= 1'b0;
    else     r_lockup <= (w_sreg_nxt == '0);
  end

  assign lockup = r_lockup;
`endif

  assign data_out   = r_data_out;
  assign data_2_dis = r_data_2_dis;
  assign sample_vld = r_sample_vld;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng (default 14-bit configuration). Directed scenarios use
// constant expectations; the random scenario is compared against a behavioural
// model updated on every clock edge.
module tb_lfsr_prng;

  localparam int          W    = 14;
  localparam logic [13:0] TAPS = 14'h2221;
  localparam logic [13:0] SEED = 14'h0001;

  logic          sysclk = 1'b0;
  logic          rst = 1'b0, step_en = 1'b0, load = 1'b0, sample = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic [W-1:0]  data_out, data_2_dis;
  logic          sample_vld, lockup, wrap;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural model state
  logic [W-1:0] m_sreg, m_start, m_prev, m_dout, m_d2;
  logic         m_sq, m_vld, m_wrap, m_lock;

  lfsr_prng #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED)) dut (
    .sysclk(sysclk), .rst(rst), .step_en(step_en), .load(load),
    .seed_in(seed_in), .sample(sample), .data_out(data_out),
    .data_2_dis(data_2_dis), .sample_vld(sample_vld), .lockup(lockup),
    .wrap(wrap)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic [W-1:0] m_next(input logic [W-1:0] s);
    int fb = 0;
    for (int i = 0; i < W; i++) if (TAPS[i] && s[i]) fb = fb ^ 1;
    return W'((int'(s) * 2 + fb) % (1 << W));
  endfunction

  function automatic bit guard_on();
`ifdef LFSR_ZERO_GUARD_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_edge();
    logic [W-1:0] ns;
    if (rst) begin
      m_sreg = SEED; m_start = SEED; m_prev = '0; m_sq = 0;
      m_dout = '0; m_d2 = '0; m_vld = 0; m_wrap = 0; m_lock = 0;
    end else begin
      m_vld = sample && !m_sq;
      if (m_vld) begin m_dout = m_sreg; m_d2 = m_prev; end
      m_sq = sample;
      m_wrap = 0;
      if (load) begin
        ns = (guard_on() && seed_in == 0) ? SEED : seed_in;
        m_prev = m_sreg; m_sreg = ns; m_start = ns;
      end else if (step_en) begin
        ns = (guard_on() && m_sreg == 0) ? SEED : m_next(m_sreg);
        m_wrap = (ns == m_start);
        m_prev = m_sreg; m_sreg = ns;
      end
      m_lock = (m_sreg == 0);
    end
  endtask

  // one clock edge; inputs were set away from the edge, outputs settle by #1
  task automatic tick();
    @(posedge sysclk);
    m_edge();
    #1;
  endtask

  task automatic set_in(input logic r, input logic s, input logic l,
                        input logic [W-1:0] sd, input logic sm);
    rst = r; step_en = s; load = l; seed_in = sd; sample = sm;
  endtask

  task automatic do_reset();
    set_in(1, 0, 0, '0, 0);
    tick();
    set_in(0, 0, 0, '0, 0);
  endtask

  // capture the current state through a fresh sample rising edge
  task automatic peek();
    set_in(0, 0, 0, '0, 0); tick();
    sample = 1'b1;          tick();
    sample = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] seq [6];
    seq = '{14'h0003, 14'h0007, 14'h000F, 14'h001F, 14'h003F, 14'h007E};
    do_reset();
    n_tests++; if (data_out !== 14'h0) begin n_fail++; $display("FAIL reset_dout got %h want 0000", data_out); end
    n_tests++; if (data_2_dis !== 14'h0) begin n_fail++; $display("FAIL reset_d2 got %h want 0000", data_2_dis); end
    n_tests++; if (sample_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", sample_vld); end
    n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b want 0", wrap); end
    n_tests++; if (lockup !== 1'b0) begin n_fail++; $display("FAIL reset_lockup got %b want 0", lockup); end
    for (int k = 0; k < 6; k++) begin
      set_in(0, 1, 0, '0, 0); tick();
      n_tests++; if (wrap !== 1'b0 || lockup !== 1'b0) begin n_fail++; $display("FAIL seq_flags step %0d got wrap=%b lockup=%b want 0 0", k+1, wrap, lockup); end
      set_in(0, 0, 0, '0, 1); tick();
      n_tests++; if (data_out !== seq[k]) begin n_fail++; $display("FAIL seq_state step %0d got %h want %h", k+1, data_out, seq[k]); end
    end
    sample = 1'b0;
  endtask

  task automatic test_wrap();
    int first_wrap = 0, wrap_cnt = 0;
    do_reset();
    step_en = 1'b1;
    for (int i = 1; i <= 16383; i++) begin
      tick();
      if (wrap === 1'b1) begin
        wrap_cnt++;
        if (first_wrap == 0) first_wrap = i;
      end
    end
    step_en = 1'b0;
    n_tests++; if (first_wrap != 16383 || wrap_cnt != 1) begin n_fail++; $display("FAIL wrap_period got first=%0d count=%0d want first=16383 count=1", first_wrap, wrap_cnt); end
    tick();
    n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse got %b want 0", wrap); end
    peek();
    n_tests++; if (data_out !== 14'h0001) begin n_fail++; $display("FAIL wrap_state got %h want 0001", data_out); end
  endtask

  task automatic test_sample();
    do_reset();
    set_in(0, 1, 0, '0, 0); tick(); tick();
    set_in(0, 0, 0, '0, 1); tick();
    n_tests++; if (data_out !== 14'h0007 || data_2_dis !== 14'h0003) begin n_fail++; $display("FAIL sample_capture got %h/%h want 0007/0003", data_out, data_2_dis); end
    n_tests++; if (sample_vld !== 1'b1) begin n_fail++; $display("FAIL sample_vld got %b want 1", sample_vld); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (sample_vld !== 1'b0) begin n_fail++; $display("FAIL sample_held cycle %0d got %b want 0", k, sample_vld); end
    end
    sample = 1'b0;
  endtask

  task automatic test_load_priority();
    do_reset();
    set_in(0, 1, 0, '0, 0); tick(); tick();
    set_in(0, 1, 1, 14'h1234, 1); tick();
    n_tests++; if (data_out !== 14'h0007 || sample_vld !== 1'b1) begin n_fail++; $display("FAIL load_presample got %h vld=%b want 0007 vld=1", data_out, sample_vld); end
    n_tests++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL load_wrap got %b want 0", wrap); end
    peek();
    n_tests++; if (data_out !== 14'h1234 || data_2_dis !== 14'h0007) begin n_fail++; $display("FAIL load_state got %h/%h want 1234/0007", data_out, data_2_dis); end
    set_in(0, 1, 0, '0, 0); tick();
    peek();
    n_tests++; if (data_out !== 14'h2468 || data_2_dis !== 14'h1234) begin n_fail++; $display("FAIL load_step got %h/%h want 2468/1234", data_out, data_2_dis); end
  endtask

  task automatic test_zero_load();
    logic         exp_lock;
    logic [W-1:0] exp_s0, exp_s5;
    exp_lock = guard_on() ? 1'b0 : 1'b1;
    exp_s0   = guard_on() ? 14'h0001 : 14'h0000;
    exp_s5   = guard_on() ? 14'h003F : 14'h0000;
    do_reset();
    set_in(0, 1, 0, '0, 0); tick();
    set_in(0, 0, 1, 14'h0000, 0); tick();
    load = 1'b0;
    n_tests++; if (lockup !== exp_lock) begin n_fail++; $display("FAIL zero_lockup got %b want %b", lockup, exp_lock); end
    peek();
    n_tests++; if (data_out !== exp_s0) begin n_fail++; $display("FAIL zero_state got %h want %h", data_out, exp_s0); end
    for (int k = 0; k < 5; k++) begin
      set_in(0, 1, 0, '0, 0); tick();
      n_tests++; if (lockup !== exp_lock) begin n_fail++; $display("FAIL zero_step_lockup step %0d got %b want %b", k, lockup, exp_lock); end
      if (!guard_on()) begin
        n_tests++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL zero_step_wrap step %0d got %b want 1", k, wrap); end
      end
    end
    peek();
    n_tests++; if (data_out !== exp_s5) begin n_fail++; $display("FAIL zero_after_steps got %h want %h", data_out, exp_s5); end
    set_in(0, 0, 1, 14'h0005, 0); tick();
    load = 1'b0;
    n_tests++; if (lockup !== 1'b0) begin n_fail++; $display("FAIL zero_recover got %b want 0", lockup); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    set_in(0, 1, 0, '0, 0); tick(); tick(); tick();
    peek();
    set_in(1, 1, 1, 14'h1234, 1); tick();
    n_tests++; if (data_out !== 14'h0 || data_2_dis !== 14'h0) begin n_fail++; $display("FAIL rst_mid_data got %h/%h want 0000/0000", data_out, data_2_dis); end
    n_tests++; if (sample_vld !== 1'b0 || wrap !== 1'b0 || lockup !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags got vld=%b wrap=%b lock=%b want 0 0 0", sample_vld, wrap, lockup); end
    set_in(0, 0, 0, '0, 1); tick();
    n_tests++; if (sample_vld !== 1'b1 || data_out !== 14'h0001 || data_2_dis !== 14'h0) begin n_fail++; $display("FAIL rst_mid_sample got vld=%b %h/%h want vld=1 0001/0000", sample_vld, data_out, data_2_dis); end
    sample = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge sysclk);
      rst     = ($urandom_range(0, 99) == 0);
      load    = ($urandom_range(0, 9) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 14'h0 : W'($urandom);
      step_en = $urandom_range(0, 1) == 1;
      sample  = $urandom_range(0, 2) == 0;
      tick();
      n_tests++;
      if (data_out !== m_dout || data_2_dis !== m_d2 || sample_vld !== m_vld ||
          wrap !== m_wrap || lockup !== (guard_on() ? 1'b0 : m_lock)) begin
        n_fail++;
        $display("FAIL random cycle %0d got dout=%h d2=%h vld=%b wrap=%b lock=%b want dout=%h d2=%h vld=%b wrap=%b lock=%b",
                 c, data_out, data_2_dis, sample_vld, wrap, lockup,
                 m_dout, m_d2, m_vld, m_wrap, guard_on() ? 1'b0 : m_lock);
      end
    end
    set_in(0, 0, 0, '0, 0);
  endtask

  initial begin
    @(negedge sysclk);
    test_reset();
    test_wrap();
    test_sample();
    test_load_priority();
    test_zero_load();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
